// File: rtl/bcd_counter_mod_04.sv
// bcd_counter_mod_04: parametrised multi-digit BCD modulo-N counter.
// DIGITS BCD digits, counting 0..MODULUS-1 up or down, with a synchronous
// preset, a registered one-cycle wrap pulse (cout_04) and a combinational
// terminal count (tc_04) so stages can be chained sec -> min -> hour.
// Optional build macro BCD_CNT_SAT_EN: saturate at the range ends instead
// of wrapping; cout_04 then marks only the first saturating attempt.
module bcd_counter_mod_04 #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic                  clk_04,
  input  logic                  rst_n_04,
  input  logic                  en_04,
  input  logic                  up_04,
  input  logic                  load_04,
  input  logic [4*DIGITS-1:0]   load_val_04,
  output logic [4*DIGITS-1:0]   dout_04,
  output logic                  cout_04,
  output logic                  tc_04
);

  localparam int W = 4 * DIGITS;

  // 10^n, used to bound MODULUS at elaboration time
  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Binary integer to packed BCD, digit 0 in the low nibble
  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           rem;
    r   = '0;
    rem = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return r;
  endfunction

  localparam int           MAX_MOD = pow10(DIGITS);
  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  // Reject illegal parameter combinations while elaborating
  if (DIGITS < 1 || DIGITS > 4 || MODULUS < 2 || MODULUS > MAX_MOD) begin : g_param_check
    $error("bcd_counter_mod_04: illegal DIGITS/MODULUS combination");
  end

  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic         carry;
  logic         borrow;
  logic         at_max;
  logic         at_zero;
  logic         load_ok;

  assign at_max  = (dout_04 == MAX_BCD);
  assign at_zero = (dout_04 == '0);

  // Terminal count is purely combinational so the next stage steps on the same edge
  assign tc_04 = en_04 & ~load_04 & (up_04 ? at_max : at_zero);

  // Per-digit BCD increment and decrement with ripple carry/borrow across digits
  always_comb begin
    inc_val = dout_04;
    dec_val = dout_04;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (dout_04[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = dout_04[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (dout_04[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = dout_04[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // A preset is accepted only if every nibble is BCD and the value is in range;
  // for valid BCD the packed compare orders the same as the decimal value
  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val_04[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
    if (load_val_04 > MAX_BCD) load_ok = 1'b0;
  end

`ifdef BCD_CNT_SAT_EN
  logic sat_seen;

  // Saturating counter: hold at the range ends, pulse cout_04 on the first attempt only
  always_ff @(posedge clk_04 or negedge rst_n_04) begin
    if (!rst_n_04) begin
      dout_04  <= '0;
      cout_04  <= 1'b0;
      sat_seen <= 1'b0;
    end else if (load_04) begin
      dout_04  <= load_ok ? load_val_04 : '0;
      cout_04  <= 1'b0;
      sat_seen <= 1'b0;
    end else if (en_04) begin
      if (up_04 ? at_max : at_zero) begin
        cout_04  <= ~sat_seen;
        sat_seen <= 1'b1;
      end else begin
        dout_04  <= up_04 ? inc_val : dec_val;
        cout_04  <= 1'b0;
        sat_seen <= 1'b0;
      end
    end else begin
      cout_04  <= 1'b0;
      sat_seen <= 1'b0;
    end
  end
`else
  // Wrapping counter: load beats enable beats hold; cout_04 marks each wrap for one cycle
  always_ff @(posedge clk_04 or negedge rst_n_04) begin
    if (!rst_n_04) begin
      dout_04 <= '0;
      cout_04 <= 1'b0;
    end else if (load_04) begin
      dout_04 <= load_ok ? load_val_04 : '0;
      cout_04 <= 1'b0;
    end else if (en_04) begin
      if (up_04) begin
        dout_04 <= at_max ? '0 : inc_val;
        cout_04 <= at_max;
      end else begin
        dout_04 <= at_zero ? MAX_BCD : dec_val;
        cout_04 <= at_zero;
      end
    end else begin
      cout_04 <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_counter_mod_04.sv
// tb_bcd_counter_mod_04: directed bench for bcd_counter_mod_04 (default
// mod-60 instance, a sec/min/hour cascade and a DIGITS=1 MODULUS=7 instance
// whose expectations follow the BCD_CNT_SAT_EN build macro).
module tb_bcd_counter_mod_04;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up, load;
  logic [7:0] load_val;
  logic [7:0] dout;
  logic       cout, tc;

  logic       c_load, c_tick;
  logic [7:0] s_val, m_val, h_val;
  logic [7:0] s_dout, m_dout, h_dout;
  logic       s_cout, m_cout, h_cout;
  logic       s_tc, m_tc, h_tc;

  logic       m7_en, m7_up, m7_load;
  logic [3:0] m7_val;
  logic [3:0] m7_dout;
  logic       m7_cout, m7_tc;

  int n_checks = 0;
  int n_pass   = 0;

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  bcd_counter_mod_04 #(.DIGITS(2), .MODULUS(60)) u_dut (
    .clk_04(clk), .rst_n_04(rst_n), .en_04(en), .up_04(up), .load_04(load),
    .load_val_04(load_val), .dout_04(dout), .cout_04(cout), .tc_04(tc));

  bcd_counter_mod_04 #(.DIGITS(2), .MODULUS(60)) u_sec (
    .clk_04(clk), .rst_n_04(rst_n), .en_04(c_tick), .up_04(1'b1), .load_04(c_load),
    .load_val_04(s_val), .dout_04(s_dout), .cout_04(s_cout), .tc_04(s_tc));

  bcd_counter_mod_04 #(.DIGITS(2), .MODULUS(60)) u_min (
    .clk_04(clk), .rst_n_04(rst_n), .en_04(s_tc), .up_04(1'b1), .load_04(c_load),
    .load_val_04(m_val), .dout_04(m_dout), .cout_04(m_cout), .tc_04(m_tc));

  bcd_counter_mod_04 #(.DIGITS(2), .MODULUS(24)) u_hour (
    .clk_04(clk), .rst_n_04(rst_n), .en_04(m_tc), .up_04(1'b1), .load_04(c_load),
    .load_val_04(h_val), .dout_04(h_dout), .cout_04(h_cout), .tc_04(h_tc));

  bcd_counter_mod_04 #(.DIGITS(1), .MODULUS(7)) u_m7 (
    .clk_04(clk), .rst_n_04(rst_n), .en_04(m7_en), .up_04(m7_up), .load_04(m7_load),
    .load_val_04(m7_val), .dout_04(m7_dout), .cout_04(m7_cout), .tc_04(m7_tc));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
    c_load = 1'b0; c_tick = 1'b0; s_val = 8'h00; m_val = 8'h00; h_val = 8'h00;
    m7_en = 1'b0; m7_up = 1'b1; m7_load = 1'b0; m7_val = 4'h0;
    #12;
    n_checks++; if (dout !== 8'h00) $display("[TB] FAIL reset_dout got=%h exp=00", dout); else n_pass++;
    n_checks++; if (cout !== 1'b0) $display("[TB] FAIL reset_cout got=%b exp=0", cout); else n_pass++;
    n_checks++; if (tc !== 1'b0) $display("[TB] FAIL reset_tc_idle got=%b exp=0", tc); else n_pass++;
    en = 1'b1; up = 1'b0; #1;
    n_checks++; if (tc !== 1'b1) $display("[TB] FAIL reset_tc_down got=%b exp=1", tc); else n_pass++;
    en = 1'b0; up = 1'b1;
    #5 rst_n = 1'b1;
    step();
  endtask

  task automatic test_count_up();
    int exp_v;
    int pulses;
    exp_v = 0; pulses = 0;
    en = 1'b1; up = 1'b1; #1;
    for (int k = 1; k <= 61; k++) begin
      n_checks++;
      if (tc !== (exp_v == 59)) $display("[TB] FAIL up_tc k=%0d got=%b exp=%b", k, tc, exp_v == 59);
      else n_pass++;
      step();
      exp_v = (exp_v + 1) % 60;
      n_checks++;
      if (dout !== bcd2(exp_v)) $display("[TB] FAIL up_dout k=%0d got=%h exp=%h", k, dout, bcd2(exp_v));
      else n_pass++;
      n_checks++;
      if (cout !== (k == 60)) $display("[TB] FAIL up_cout k=%0d got=%b exp=%b", k, cout, k == 60);
      else n_pass++;
      if (cout === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 1) $display("[TB] FAIL up_pulse_count got=%0d exp=1", pulses); else n_pass++;
    en = 1'b0;
  endtask

  task automatic test_down();
    load = 1'b1; load_val = 8'h01; en = 1'b0;
    step();
    n_checks++; if (dout !== 8'h01) $display("[TB] FAIL down_load got=%h exp=01", dout); else n_pass++;
    load = 1'b0; en = 1'b1; up = 1'b0;
    step();
    n_checks++; if (dout !== 8'h00 || cout !== 1'b0) $display("[TB] FAIL down_00 got=%h/%b exp=00/0", dout, cout); else n_pass++;
    n_checks++; if (tc !== 1'b1) $display("[TB] FAIL down_tc got=%b exp=1", tc); else n_pass++;
    step();
    n_checks++; if (dout !== 8'h59 || cout !== 1'b1) $display("[TB] FAIL down_wrap got=%h/%b exp=59/1", dout, cout); else n_pass++;
    step();
    n_checks++; if (dout !== 8'h58 || cout !== 1'b0) $display("[TB] FAIL down_58 got=%h/%b exp=58/0", dout, cout); else n_pass++;
    en = 1'b0; up = 1'b1;
  endtask

  task automatic test_preset();
    load = 1'b1; en = 1'b1; up = 1'b1; load_val = 8'h37; #1;
    n_checks++; if (tc !== 1'b0) $display("[TB] FAIL preset_tc got=%b exp=0", tc); else n_pass++;
    step();
    n_checks++; if (dout !== 8'h37 || cout !== 1'b0) $display("[TB] FAIL preset_37 got=%h/%b exp=37/0", dout, cout); else n_pass++;
    load_val = 8'h3A; step();
    n_checks++; if (dout !== 8'h00) $display("[TB] FAIL preset_3A got=%h exp=00", dout); else n_pass++;
    load_val = 8'h59; step();
    n_checks++; if (dout !== 8'h59) $display("[TB] FAIL preset_59 got=%h exp=59", dout); else n_pass++;
    load_val = 8'h60; step();
    n_checks++; if (dout !== 8'h00) $display("[TB] FAIL preset_60 got=%h exp=00", dout); else n_pass++;
    load_val = 8'h75; step();
    n_checks++; if (dout !== 8'h00) $display("[TB] FAIL preset_75 got=%h exp=00", dout); else n_pass++;
    load_val = 8'h59; step();
    load_val = 8'h10; step();
    n_checks++; if (dout !== 8'h10 || cout !== 1'b0) $display("[TB] FAIL preset_over_wrap got=%h/%b exp=10/0", dout, cout); else n_pass++;
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_hold();
    load = 1'b1; load_val = 8'h59; step();
    load = 1'b0; en = 1'b1; up = 1'b1; step();
    n_checks++; if (dout !== 8'h00 || cout !== 1'b1) $display("[TB] FAIL hold_wrap got=%h/%b exp=00/1", dout, cout); else n_pass++;
    en = 1'b0; step();
    n_checks++; if (dout !== 8'h00 || cout !== 1'b0) $display("[TB] FAIL hold_clear got=%h/%b exp=00/0", dout, cout); else n_pass++;
    load_val = 8'h23; load = 1'b1; step(); load = 1'b0; step(); step();
    n_checks++; if (dout !== 8'h23) $display("[TB] FAIL hold_value got=%h exp=23", dout); else n_pass++;
  endtask

  task automatic test_back_to_back();
    load = 1'b1; load_val = 8'h10; step();
    load = 1'b0; en = 1'b1; up = 1'b1; step();
    n_checks++; if (dout !== 8'h11) $display("[TB] FAIL b2b_up got=%h exp=11", dout); else n_pass++;
    up = 1'b0; step();
    n_checks++; if (dout !== 8'h10) $display("[TB] FAIL b2b_down got=%h exp=10", dout); else n_pass++;
    step();
    n_checks++; if (dout !== 8'h09) $display("[TB] FAIL b2b_borrow got=%h exp=09", dout); else n_pass++;
    up = 1'b1; step();
    n_checks++; if (dout !== 8'h10) $display("[TB] FAIL b2b_carry got=%h exp=10", dout); else n_pass++;
    en = 1'b0;
  endtask

  task automatic test_mid_reset();
    load = 1'b1; load_val = 8'h42; step();
    load = 1'b0;
    n_checks++; if (dout !== 8'h42) $display("[TB] FAIL midrst_pre got=%h exp=42", dout); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (dout !== 8'h00 || cout !== 1'b0) $display("[TB] FAIL midrst_async got=%h/%b exp=00/0", dout, cout); else n_pass++;
    #2 rst_n = 1'b1;
    en = 1'b1; up = 1'b1;
    step();
    n_checks++; if (dout !== 8'h01) $display("[TB] FAIL midrst_resume got=%h exp=01", dout); else n_pass++;
    en = 1'b0;
  endtask

  task automatic test_cascade();
    c_load = 1'b1; c_tick = 1'b1; s_val = 8'h59; m_val = 8'h59; h_val = 8'h23;
    step();
    c_load = 1'b0; #1;
    n_checks++; if ({h_dout, m_dout, s_dout} !== 24'h235959) $display("[TB] FAIL casc_preset got=%h exp=235959", {h_dout, m_dout, s_dout}); else n_pass++;
    n_checks++; if (h_tc !== 1'b1) $display("[TB] FAIL casc_hour_tc got=%b exp=1", h_tc); else n_pass++;
    step();
    c_tick = 1'b0;
    n_checks++; if ({h_dout, m_dout, s_dout} !== 24'h000000) $display("[TB] FAIL casc_tick got=%h exp=000000", {h_dout, m_dout, s_dout}); else n_pass++;
    n_checks++; if ({h_cout, m_cout, s_cout} !== 3'b111) $display("[TB] FAIL casc_cout got=%b exp=111", {h_cout, m_cout, s_cout}); else n_pass++;
    step();
    n_checks++; if ({h_cout, m_cout, s_cout} !== 3'b000) $display("[TB] FAIL casc_cout_clear got=%b exp=000", {h_cout, m_cout, s_cout}); else n_pass++;
  endtask

  task automatic test_mod7();
    logic [3:0] exp_up [1:9];
    logic [3:0] exp_dn [1:2];
`ifdef BCD_CNT_SAT_EN
    exp_up = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6, 4'd6, 4'd6};
    exp_dn = '{4'd0, 4'd0};
`else
    exp_up = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0, 4'd1, 4'd2};
    exp_dn = '{4'd6, 4'd5};
`endif
    m7_load = 1'b1; m7_val = 4'hB; step();
    n_checks++; if (m7_dout !== 4'h0) $display("[TB] FAIL m7_load_B got=%h exp=0", m7_dout); else n_pass++;
    m7_val = 4'h7; step();
    n_checks++; if (m7_dout !== 4'h0) $display("[TB] FAIL m7_load_7 got=%h exp=0", m7_dout); else n_pass++;
    m7_load = 1'b0; m7_en = 1'b1; m7_up = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      n_checks++;
      if (m7_dout !== exp_up[k]) $display("[TB] FAIL m7_up_dout k=%0d got=%h exp=%h", k, m7_dout, exp_up[k]);
      else n_pass++;
      n_checks++;
      if (m7_cout !== (k == 7)) $display("[TB] FAIL m7_up_cout k=%0d got=%b exp=%b", k, m7_cout, k == 7);
      else n_pass++;
    end
    m7_en = 1'b0; m7_load = 1'b1; m7_val = 4'h0; step();
    m7_load = 1'b0; m7_en = 1'b1; m7_up = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      step();
      n_checks++;
      if (m7_dout !== exp_dn[k] || m7_cout !== (k == 1))
        $display("[TB] FAIL m7_down k=%0d got=%h/%b exp=%h/%b", k, m7_dout, m7_cout, exp_dn[k], k == 1);
      else n_pass++;
    end
    m7_en = 1'b0;
  endtask

  // Run every scenario in order and report the totals
  initial begin
    test_reset();
    test_count_up();
    test_down();
    test_preset();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    test_cascade();
    test_mod7();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
